// File: rtl/mem_stream_server.sv
// Memory-side responder for the streaming read/write handshake: a scratch RAM served
// through two independent latency-programmable beat FSMs plus a separate host port.
module mem_stream_server #(
  parameter int ADDR_WID = 10,
  parameter int DATA_WID = 32,
  parameter int RD_LAT   = 2,
  parameter int WR_LAT   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                read_enable,
  input  logic [63:0]         read_addr,
  input  logic                finish_read,
  output logic [63:0]         read_ready,
  output logic [DATA_WID-1:0] read_data,
  input  logic                write_enable,
  input  logic [63:0]         write_addr,
  input  logic [DATA_WID-1:0] write_data,
  input  logic                finish_write,
  output logic [63:0]         write_ready,
  input  logic                host_we,
  input  logic [ADDR_WID-1:0] host_addr,
  input  logic [DATA_WID-1:0] host_wdata,
  output logic [DATA_WID-1:0] host_rdata,
  output logic                addr_err,
  output logic [31:0]         rd_beats,
  output logic [31:0]         wr_beats
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] RD_LAT_C = CNT_W'(RD_LAT);
  localparam logic [CNT_W-1:0] WR_LAT_C = CNT_W'(WR_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2, R_HOLD = 2'd3} rd_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_ACK  = 2'd2, W_HOLD = 2'd3} wr_state_t;

  rd_state_t            rd_state_q, rd_state_d;
  wr_state_t            wr_state_q, wr_state_d;
  logic [CNT_W-1:0]     rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic                 read_ready_q, read_ready_d, write_ready_q, write_ready_d;
  logic [DATA_WID-1:0]  read_data_q, read_data_d, host_rdata_q, host_rdata_d;
  logic                 addr_err_q, addr_err_d;
  logic [31:0]          rd_beats_q, rd_beats_d, wr_beats_q, wr_beats_d;
  logic                 rd_fire_s, wr_fire_s, wr_commit_s;
  logic [DATA_WID-1:0]  mem_q [2**ADDR_WID];

  function automatic logic addr_bad(input logic [63:0] a);
    return (a[63:ADDR_WID+2] != '0) || (a[1:0] != 2'b00);
  endfunction

  function automatic logic [ADDR_WID-1:0] addr_idx(input logic [63:0] a);
    return a[ADDR_WID+1:2];
  endfunction

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state_q    <= R_IDLE;
      wr_state_q    <= W_IDLE;
      rd_cnt_q      <= '0;
      wr_cnt_q      <= '0;
      read_ready_q  <= 1'b0;
      write_ready_q <= 1'b0;
      read_data_q   <= '0;
      host_rdata_q  <= '0;
      addr_err_q    <= 1'b0;
      rd_beats_q    <= 32'd0;
      wr_beats_q    <= 32'd0;
    end else begin
      rd_state_q    <= rd_state_d;
      wr_state_q    <= wr_state_d;
      rd_cnt_q      <= rd_cnt_d;
      wr_cnt_q      <= wr_cnt_d;
      read_ready_q  <= read_ready_d;
      write_ready_q <= write_ready_d;
      read_data_q   <= read_data_d;
      host_rdata_q  <= host_rdata_d;
      addr_err_q    <= addr_err_d;
      rd_beats_q    <= rd_beats_d;
      wr_beats_q    <= wr_beats_d;
    end
  end

  // Scratch RAM; the stream write is last so it wins a same-word collision with the host
  always_ff @(posedge clk) begin
    if (host_we) mem_q[host_addr] <= host_wdata;
    if (wr_commit_s) mem_q[addr_idx(write_addr)] <= write_data;
  end

  // Read FSM next state
  always_comb begin
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    if (!read_enable) begin
      rd_state_d = R_IDLE;
    end else begin
      case (rd_state_q)
        R_IDLE: begin rd_state_d = R_WAIT; rd_cnt_d = RD_LAT_C; end
        R_WAIT: begin
          rd_cnt_d = rd_cnt_q - CNT_ONE;
          if (rd_cnt_q == CNT_ONE) rd_state_d = R_RESP;
          else rd_state_d = R_WAIT;
        end
        R_RESP: rd_state_d = R_HOLD;
        R_HOLD: begin
          if (finish_read) begin rd_state_d = R_WAIT; rd_cnt_d = RD_LAT_C; end
          else rd_state_d = R_HOLD;
        end
        default: rd_state_d = R_IDLE;
      endcase
    end
  end

  // Write FSM next state
  always_comb begin
    wr_state_d = wr_state_q;
    wr_cnt_d   = wr_cnt_q;
    if (!write_enable) begin
      wr_state_d = W_IDLE;
    end else begin
      case (wr_state_q)
        W_IDLE: begin wr_state_d = W_WAIT; wr_cnt_d = WR_LAT_C; end
        W_WAIT: begin
          wr_cnt_d = wr_cnt_q - CNT_ONE;
          if (wr_cnt_q == CNT_ONE) wr_state_d = W_ACK;
          else wr_state_d = W_WAIT;
        end
        W_ACK: wr_state_d = W_HOLD;
        W_HOLD: begin
          if (finish_write) begin wr_state_d = W_WAIT; wr_cnt_d = WR_LAT_C; end
          else wr_state_d = W_HOLD;
        end
        default: wr_state_d = W_IDLE;
      endcase
    end
  end

  // Beat outputs, data capture, counters and the sticky error flag
  always_comb begin
    rd_fire_s     = read_enable && (rd_state_q == R_WAIT) && (rd_cnt_q == CNT_ONE);
    wr_fire_s     = write_enable && (wr_state_q == W_WAIT) && (wr_cnt_q == CNT_ONE);
    wr_commit_s   = wr_fire_s && !addr_bad(write_addr);
    read_ready_d  = rd_fire_s;
    write_ready_d = wr_fire_s;
    host_rdata_d  = mem_q[host_addr];
    if (rd_fire_s) begin
      if (addr_bad(read_addr)) read_data_d = '0;
      else read_data_d = mem_q[addr_idx(read_addr)];
    end else begin
      read_data_d = read_data_q;
    end
    addr_err_d = addr_err_q | (rd_fire_s & addr_bad(read_addr)) | (wr_fire_s & addr_bad(write_addr));
    if (rd_state_q == R_RESP) rd_beats_d = rd_beats_q + 32'd1;
    else rd_beats_d = rd_beats_q;
    if (wr_state_q == W_ACK) wr_beats_d = wr_beats_q + 32'd1;
    else wr_beats_d = wr_beats_q;
  end

  assign read_ready  = {63'd0, read_ready_q};
  assign write_ready = {63'd0, write_ready_q};
  assign read_data   = read_data_q;
  assign host_rdata  = host_rdata_q;
  assign addr_err    = addr_err_q;
  assign rd_beats    = rd_beats_q;
  assign wr_beats    = wr_beats_q;

endmodule

// File: tb/tb_mem_stream_server.sv
// Directed bench for mem_stream_server: stream beats, latency, collisions,
// out-of-range handling, aborts and asynchronous reset.
module tb_mem_stream_server;

  logic        clk = 1'b0;
  logic        reset;
  logic        read_enable, finish_read, write_enable, finish_write, host_we;
  logic [63:0] read_addr, write_addr;
  logic [63:0] read_ready, write_ready;
  logic [31:0] read_data, write_data, host_wdata, host_rdata, rd_beats, wr_beats;
  logic [9:0]  host_addr;
  logic        addr_err;
  int          n_vec = 0;
  int          n_err = 0;

  mem_stream_server dut (
    .clk(clk), .reset(reset),
    .read_enable(read_enable), .read_addr(read_addr), .finish_read(finish_read),
    .read_ready(read_ready), .read_data(read_data),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .finish_write(finish_write), .write_ready(write_ready),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .addr_err(addr_err), .rd_beats(rd_beats), .wr_beats(wr_beats)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic host_wr(input logic [9:0] a, input logic [31:0] d);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    tick(1);
    host_we = 1'b0;
  endtask

  task automatic host_rd(input logic [9:0] a, input logic [31:0] exp, input string tag);
    host_addr = a;
    tick(1);
    chk(tag, host_rdata, exp);
  endtask

  // One read beat: start or finish, count cycles to ready (RD_LAT+1 ticks from drive), check pulse
  task automatic rd_beat(input logic [63:0] a, input logic first, input logic [31:0] exp, input string tag);
    int c;
    read_addr = a;
    if (first) read_enable = 1'b1;
    else finish_read = 1'b1;
    tick(1);
    finish_read = 1'b0;
    c = 1;
    while (read_ready[0] !== 1'b1 && c < 20) begin tick(1); c++; end
    chk({tag, " lat"}, c, 3);
    chk({tag, " data"}, read_data, exp);
    tick(1);
    chk({tag, " pulse"}, read_ready, 64'd0);
  endtask

  task automatic wr_beat(input logic [63:0] a, input logic first, input logic [31:0] d, input string tag);
    int c;
    write_addr = a; write_data = d;
    if (first) write_enable = 1'b1;
    else finish_write = 1'b1;
    tick(1);
    finish_write = 1'b0;
    c = 1;
    while (write_ready[0] !== 1'b1 && c < 20) begin tick(1); c++; end
    chk({tag, " lat"}, c, 3);
    tick(1);
    chk({tag, " pulse"}, write_ready, 64'd0);
  endtask

  initial begin
    reset = 1'b1; read_enable = 1'b0; finish_read = 1'b0; write_enable = 1'b0; finish_write = 1'b0;
    host_we = 1'b0; read_addr = 64'd0; write_addr = 64'd0; write_data = 32'd0;
    host_addr = 10'd0; host_wdata = 32'd0;
    tick(2);
    chk("rst read_ready", read_ready, 64'd0);
    chk("rst write_ready", write_ready, 64'd0);
    chk("rst read_data", read_data, 64'd0);
    chk("rst host_rdata", host_rdata, 64'd0);
    chk("rst addr_err", addr_err, 64'd0);
    chk("rst rd_beats", rd_beats, 64'd0);
    chk("rst wr_beats", wr_beats, 64'd0);
    reset = 1'b0;
    tick(1);

    // Read stream over preloaded words 0..3
    for (int i = 0; i < 4; i++) host_wr(10'(i), 32'(10 + i));
    rd_beat(64'd0, 1'b1, 32'd10, "rd0");
    rd_beat(64'd4, 1'b0, 32'd11, "rd1");
    rd_beat(64'd8, 1'b0, 32'd12, "rd2");
    rd_beat(64'd12, 1'b0, 32'd13, "rd3");
    read_enable = 1'b0;
    tick(1);
    chk("rd_beats 4", rd_beats, 64'd4);

    // Write stream at byte 0x100 (words 64..67)
    wr_beat(64'h100, 1'b1, 32'hA0, "wr0");
    wr_beat(64'h104, 1'b0, 32'hA1, "wr1");
    wr_beat(64'h108, 1'b0, 32'hA2, "wr2");
    wr_beat(64'h10C, 1'b0, 32'hA3, "wr3");
    write_enable = 1'b0;
    tick(1);
    chk("wr_beats 4", wr_beats, 64'd4);
    host_rd(10'd64, 32'hA0, "host w64");
    host_rd(10'd65, 32'hA1, "host w65");
    host_rd(10'd66, 32'hA2, "host w66");
    host_rd(10'd67, 32'hA3, "host w67");

    // Concurrent streams; first beats read and write word 2 at the same edge
    read_addr = 64'd8; write_addr = 64'd8; write_data = 32'h55;
    read_enable = 1'b1; write_enable = 1'b1;
    tick(3);
    chk("cc rd ready", read_ready, 64'd1);
    chk("cc wr ready", write_ready, 64'd1);
    chk("cc rd old data", read_data, 64'd12);
    tick(1);
    read_addr = 64'h100; write_addr = 64'd12; write_data = 32'h66;
    finish_read = 1'b1; finish_write = 1'b1;
    tick(1);
    finish_read = 1'b0; finish_write = 1'b0;
    tick(2);
    chk("cc2 rd ready", read_ready, 64'd1);
    chk("cc2 wr ready", write_ready, 64'd1);
    chk("cc2 rd data", read_data, 64'hA0);
    tick(1);
    read_enable = 1'b0; write_enable = 1'b0;
    tick(1);
    host_rd(10'd2, 32'h55, "host w2 new");
    host_rd(10'd3, 32'h66, "host w3 new");
    chk("cc rd_beats", rd_beats, 64'd6);
    chk("cc wr_beats", wr_beats, 64'd6);

    // Out-of-range accesses
    chk("err clear", addr_err, 64'd0);
    rd_beat(64'h1_0000_0000, 1'b1, 32'd0, "oor rd");
    chk("err set rd", addr_err, 64'd1);
    wr_beat(64'h1_0000_0000, 1'b1, 32'hDEAD, "oor wr");
    read_enable = 1'b0; write_enable = 1'b0;
    tick(1);
    host_rd(10'd0, 32'd10, "oor wr dropped");
    chk("err sticky", addr_err, 64'd1);
    chk("oor rd_beats", rd_beats, 64'd7);
    chk("oor wr_beats", wr_beats, 64'd7);

    // read_enable dropped during R_WAIT aborts the beat
    read_addr = 64'd0; read_enable = 1'b1;
    tick(2);
    read_enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("abort no ready", read_ready, 64'd0);
    end
    chk("abort rd_beats", rd_beats, 64'd7);

    // Reset asserted during W_WAIT
    host_wr(10'd5, 32'h77);
    host_rd(10'd5, 32'h77, "pre-rst host");
    write_addr = 64'h14; write_data = 32'h99; write_enable = 1'b1;
    tick(2);
    reset = 1'b1;
    #1;
    chk("arst host_rdata", host_rdata, 64'd0);
    chk("arst addr_err", addr_err, 64'd0);
    chk("arst rd_beats", rd_beats, 64'd0);
    chk("arst wr_beats", wr_beats, 64'd0);
    chk("arst write_ready", write_ready, 64'd0);
    write_enable = 1'b0;
    tick(2);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("post-rst no ready", write_ready, 64'd0);
    end
    host_rd(10'd5, 32'h77, "rst no commit");

    // Host and stream write to word 6 in the same cycle
    host_wr(10'd6, 32'h11);
    write_addr = 64'h18; write_data = 32'hBB; write_enable = 1'b1;
    tick(2);
    host_we = 1'b1; host_addr = 10'd6; host_wdata = 32'hCC;
    tick(1);
    host_we = 1'b0;
    chk("col wr ready", write_ready, 64'd1);
    chk("col host pre-write", host_rdata, 64'h11);
    tick(1);
    write_enable = 1'b0;
    tick(1);
    host_rd(10'd6, 32'hBB, "col stream wins");
    chk("col wr_beats", wr_beats, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
